id_auth: RTL and testbench
==========================

ID_AUTH -- requirements
Module: id_auth

Interface
REQ-001 NUM_ENTRIES, 8, number of authorized-ID table entries (2..16).
REQ-002 GRANT_CYCLES, 16, clk cycles door_open stays high after a grant (1..65535).
REQ-003 clk  input  1  system clock, all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 ID  input  8  identifier from upstream barcode reader, valid while ID_vld high.
REQ-006 ID_vld  input  1  level; high until cleared by clr_ID_vld.
REQ-007 clr_ID_vld  output  1  one-cycle pulse acknowledging capture of ID.
REQ-008 wr_en  input  1  table write strobe.
REQ-009 wr_addr  input  $clog2(NUM_ENTRIES)  table entry index.
REQ-010 wr_data  input  8  ID to store.
REQ-011 wr_vld  input  1  valid bit stored with entry (0 = erase).
REQ-012 busy  output  1  high in any state other than IDLE.
REQ-013 grant  output  1  one-cycle pulse, ID matched.
REQ-014 deny  output  1  one-cycle pulse, ID not matched.
REQ-015 door_open  output  1  high for GRANT_CYCLES cycles after grant.

Function
REQ-016 States IDLE, SEARCH, GRANT, DENY; all outputs registered.
REQ-017 IDLE: ID_vld sampled high in cycle T -> ID latched to id_q, clr_ID_vld=1 in T+1 only, state SEARCH with idx=0 in T+1.
REQ-018 SEARCH: one entry per cycle; entry valid and data==id_q -> GRANT next cycle; else idx==NUM_ENTRIES-1 -> DENY next cycle; else idx+1.
REQ-019 Match at index k -> grant=1 in cycle T+2+k only; no match -> deny=1 in cycle T+NUM_ENTRIES+1 only.
REQ-020 GRANT: door_open high from grant cycle for exactly GRANT_CYCLES cycles via down-counter, then IDLE.
REQ-021 DENY: lasts one cycle, then IDLE.
REQ-022 ID_vld high outside IDLE ignored, no clr_ID_vld; serviced on return to IDLE.
REQ-023 Lowest matching index wins; duplicate entries harmless.
REQ-024 Table write in cycle W visible to compares from W+1; writes allowed in any state, search reads live table.
REQ-025 Invalid entries never match, including ID 8'h00.
REQ-026 grant and deny never high in same cycle; clr_ID_vld at most once per search.

Reset
REQ-027 rst_n low: state IDLE, idx 0, id_q 0, counter 0, all table valid bits 0, clr_ID_vld/grant/deny/door_open/busy 0.
REQ-028 Reset mid-SEARCH or mid-GRANT aborts immediately; door_open drops asynchronously.
REQ-029 Table data bits need not be reset; only valid bits.

Configuration
REQ-030 ID_AUTH_STATS_EN defined: outputs grant_cnt[7:0], deny_cnt[7:0] count grant/deny pulses, saturate at 8'hFF, reset to 0.
REQ-031 ID_AUTH_STATS_EN undefined: ports present, tied to 8'h00, no counter logic.

Structure
REQ-032 Package id_auth_pkg: state enum type, ID width constant 8, default NUM_ENTRIES and GRANT_CYCLES.
REQ-033 Sub-module auth_table: register file of NUM_ENTRIES x {valid,8-bit ID}, one write port, one combinational read port indexed by idx.

Verification
REQ-034 Table {0:8'h3C}, ID=8'h3C, ID_vld at T -> clr_ID_vld at T+1, grant at T+2, door_open 16 cycles.
REQ-035 Table {5:8'hA5}, ID=8'hA5 -> grant at T+7, no deny.
REQ-036 Empty table, ID=8'h00 -> deny at T+9, door_open stays 0.
REQ-037 ID_vld held high during GRANT with new ID -> no clr_ID_vld until IDLE, second search starts then.
REQ-038 Write entry 2=8'h77 in cycle T+2 of search for 8'h77 -> grant at T+4; erase entry then repeat -> deny.
REQ-039 rst_n low during GRANT cycle 5 -> door_open 0 immediately, state IDLE, table empty; with ID_AUTH_STATS_EN, 300 grants -> grant_cnt 8'hFF.

Source files
------------

// File: rtl/id_auth_pkg.sv
// Shared types and constants for the ID authorization block.
//   state_e        : controller state encoding
//   IdWidth        : width of an identifier
//   DefNumEntries  : default authorized-ID table depth
//   DefGrantCycles : default door_open hold time in clk cycles
package id_auth_pkg;

  localparam int unsigned IdWidth        = 8;
  localparam int unsigned DefNumEntries  = 8;
  localparam int unsigned DefGrantCycles = 16;

  typedef enum logic [1:0] {
    StIdle,
    StSearch,
    StGrant,
    StDeny
  } state_e;

endpackage

// File: rtl/id_auth_table.sv
// Authorized-ID register file: NUM_ENTRIES x {valid, IdWidth-bit ID}.
//   clk, rst_n              : clock, async active-low reset (clears valid bits only)
//   wr_en_i/wr_addr_i       : write strobe and entry index
//   wr_data_i/wr_vld_i      : ID and valid bit stored (valid 0 erases the entry)
//   rd_idx_i                : combinational read index
//   rd_vld_o/rd_data_o      : valid bit and ID of the entry at rd_idx_i
module auth_table
  import id_auth_pkg::*;
#(
  parameter int unsigned NUM_ENTRIES = DefNumEntries,
  localparam int unsigned IdxW = $clog2(NUM_ENTRIES)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wr_en_i,
  input  logic [IdxW-1:0]    wr_addr_i,
  input  logic [IdWidth-1:0] wr_data_i,
  input  logic               wr_vld_i,
  input  logic [IdxW-1:0]    rd_idx_i,
  output logic               rd_vld_o,
  output logic [IdWidth-1:0] rd_data_o
);

  localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_ENTRIES - 1);

  logic [NUM_ENTRIES-1:0] vld_q;
  logic [IdWidth-1:0]     data_q [NUM_ENTRIES];
  logic                   wr_hit;

  // Addresses beyond the table (non power-of-two depth) are dropped.
  assign wr_hit = wr_en_i && (wr_addr_i <= LastIdx);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
    end else if (wr_hit) begin
      vld_q[wr_addr_i] <= wr_vld_i;
    end
  end

  // Data bits carry no reset; an entry is only meaningful while its valid bit is set.
  always_ff @(posedge clk) begin
    if (wr_hit) begin
      data_q[wr_addr_i] <= wr_data_i;
    end
  end

  assign rd_vld_o  = vld_q[rd_idx_i];
  assign rd_data_o = data_q[rd_idx_i];

endmodule

// File: rtl/id_auth.sv
// ID authorization controller: latches an ID from the reader, walks the
// authorized-ID table one entry per cycle, then pulses grant (and holds
// door_open for GRANT_CYCLES cycles) or pulses deny.
//   clk, rst_n                  : clock, async active-low reset
//   id_i/id_vld_i/clr_id_vld_o  : reader handshake (level valid, pulse acknowledge)
//   wr_*_i                      : table write port
//   busy_o, grant_o, deny_o     : status and result pulses
//   door_open_o                 : door strobe following a grant
//   grant_cnt_o/deny_cnt_o      : saturating event counters when ID_AUTH_STATS_EN
//                                 is defined, otherwise tied to zero
module id_auth
  import id_auth_pkg::*;
#(
  parameter int unsigned NUM_ENTRIES  = DefNumEntries,
  parameter int unsigned GRANT_CYCLES = DefGrantCycles,
  localparam int unsigned IdxW = $clog2(NUM_ENTRIES)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [IdWidth-1:0] id_i,
  input  logic               id_vld_i,
  output logic               clr_id_vld_o,
  input  logic               wr_en_i,
  input  logic [IdxW-1:0]    wr_addr_i,
  input  logic [IdWidth-1:0] wr_data_i,
  input  logic               wr_vld_i,
  output logic               busy_o,
  output logic               grant_o,
  output logic               deny_o,
  output logic               door_open_o,
  output logic [7:0]         grant_cnt_o,
  output logic [7:0]         deny_cnt_o
);

  localparam logic [IdxW-1:0] LastIdx  = IdxW'(NUM_ENTRIES - 1);
  localparam logic [15:0]     CntStart = 16'(GRANT_CYCLES - 1);

  state_e             state_q;
  logic [IdxW-1:0]    idx_q;
  logic [IdWidth-1:0] id_q;
  logic [15:0]        cnt_q;
  logic               clr_q, grant_q, deny_q, door_q, busy_q;
  logic               rd_vld;
  logic [IdWidth-1:0] rd_data;

  auth_table #(
    .NUM_ENTRIES(NUM_ENTRIES)
  ) u_table (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en_i  (wr_en_i),
    .wr_addr_i(wr_addr_i),
    .wr_data_i(wr_data_i),
    .wr_vld_i (wr_vld_i),
    .rd_idx_i (idx_q),
    .rd_vld_o (rd_vld),
    .rd_data_o(rd_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      idx_q   <= '0;
      id_q    <= '0;
      cnt_q   <= '0;
      clr_q   <= 1'b0;
      grant_q <= 1'b0;
      deny_q  <= 1'b0;
      door_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      clr_q   <= 1'b0;
      grant_q <= 1'b0;
      deny_q  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (id_vld_i) begin
            id_q    <= id_i;
            clr_q   <= 1'b1;
            idx_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= StSearch;
          end
        end
        StSearch: begin
          // Stop at the first hit so the lowest matching index wins.
          if (rd_vld && (rd_data == id_q)) begin
            grant_q <= 1'b1;
            door_q  <= 1'b1;
            cnt_q   <= CntStart;
            state_q <= StGrant;
          end else if (idx_q == LastIdx) begin
            deny_q  <= 1'b1;
            state_q <= StDeny;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        StGrant: begin
          // The grant cycle itself is the first of the GRANT_CYCLES door cycles.
          if (cnt_q == '0) begin
            door_q  <= 1'b0;
            busy_q  <= 1'b0;
            idx_q   <= '0;
            state_q <= StIdle;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        StDeny: begin
          busy_q  <= 1'b0;
          idx_q   <= '0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign clr_id_vld_o = clr_q;
  assign grant_o      = grant_q;
  assign deny_o       = deny_q;
  assign door_open_o  = door_q;
  assign busy_o       = busy_q;

`ifdef ID_AUTH_STATS_EN
  logic [7:0] grant_cnt_q, deny_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_cnt_q <= '0;
      deny_cnt_q  <= '0;
    end else begin
      if (grant_q && (grant_cnt_q != 8'hFF)) grant_cnt_q <= grant_cnt_q + 1'b1;
      if (deny_q && (deny_cnt_q != 8'hFF))   deny_cnt_q  <= deny_cnt_q + 1'b1;
    end
  end

  assign grant_cnt_o = grant_cnt_q;
  assign deny_cnt_o  = deny_cnt_q;
`else
  assign grant_cnt_o = 8'h00;
  assign deny_cnt_o  = 8'h00;
`endif

endmodule

// File: tb/tb_id_auth.sv
// Self-checking bench for id_auth. Expected clr/grant/deny events are queued with
// their cycle number when an ID is presented; a negedge monitor pops and matches
// them against DUT pulses, and tracks the expected door_open window.
module tb_id_auth;

  localparam int KClr   = 0;
  localparam int KGrant = 1;
  localparam int KDeny  = 2;
  localparam int NEnt   = 8;

  typedef struct {
    int kind;
    int cyc;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] id;
  logic       id_vld;
  logic       clr_id_vld;
  logic       wr_en;
  logic [2:0] wr_addr;
  logic [7:0] wr_data;
  logic       wr_vld;
  logic       busy, grant, deny, door_open;
  logic [7:0] grant_cnt, deny_cnt;

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  ev_t  sb[$];
  int   door_lo = 0;
  int   door_hi = -1;
  bit   mdl_vld [NEnt];
  logic [7:0] mdl_data [NEnt];
  int   tb_grants = 0;
  int   tb_denies = 0;

  id_auth dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .id_i        (id),
    .id_vld_i    (id_vld),
    .clr_id_vld_o(clr_id_vld),
    .wr_en_i     (wr_en),
    .wr_addr_i   (wr_addr),
    .wr_data_i   (wr_data),
    .wr_vld_i    (wr_vld),
    .busy_o      (busy),
    .grant_o     (grant),
    .deny_o      (deny),
    .door_open_o (door_open),
    .grant_cnt_o (grant_cnt),
    .deny_cnt_o  (deny_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      while (sb.size() > 0 && sb[0].cyc < cyc) begin
        checks++; errors++;
        $display("FAIL missed_event: kind %0d expected at cycle %0d, now %0d",
                 sb[0].kind, sb[0].cyc, cyc);
        void'(sb.pop_front());
      end
      for (int e = 0; e < 3; e++) begin
        logic p;
        p = (e == KClr) ? clr_id_vld : (e == KGrant) ? grant : deny;
        if (p !== 1'b0) begin
          checks++;
          if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event: kind %0d at cycle %0d, none expected", e, cyc);
          end else begin
            ev_t ev;
            ev = sb.pop_front();
            if (ev.kind != e || ev.cyc != cyc) begin
              errors++;
              $display("FAIL event_match: got kind %0d at cycle %0d, expected kind %0d at %0d",
                       e, cyc, ev.kind, ev.cyc);
            end
          end
        end
      end
      checks++;
      if (door_open !== ((cyc >= door_lo && cyc <= door_hi) ? 1'b1 : 1'b0)) begin
        errors++;
        $display("FAIL door_open: cycle %0d got %b, window %0d..%0d",
                 cyc, door_open, door_lo, door_hi);
      end
    end
  end

  function automatic int model_lookup(input logic [7:0] v);
    for (int i = 0; i < NEnt; i++) if (mdl_vld[i] && mdl_data[i] == v) return i;
    return -1;
  endfunction

  // Queue the expected events of a search whose ID is sampled in cycle s.
  task automatic expect_search(input int s, input int k);
    sb.push_back('{kind: KClr, cyc: s + 1});
    if (k >= 0) begin
      sb.push_back('{kind: KGrant, cyc: s + 2 + k});
      door_lo = s + 2 + k;
      door_hi = s + 2 + k + 15;
      tb_grants++;
    end else begin
      sb.push_back('{kind: KDeny, cyc: s + NEnt + 1});
      tb_denies++;
    end
  endtask

  // Present an ID to an idle DUT; returns the sample cycle, ends one cycle later.
  task automatic drive_id(input logic [7:0] v, input int k, output int t);
    @(negedge clk);
    t = cyc;
    id = v;
    id_vld = 1'b1;
    expect_search(t, k);
    @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_search: got %b expected 1 at cycle %0d", busy, cyc);
    end
    id_vld = 1'b0;
  endtask

  task automatic search(input logic [7:0] v);
    int t;
    drive_id(v, model_lookup(v), t);
  endtask

  task automatic write_entry(input int a, input logic [7:0] d, input bit v);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 3'(a); wr_data = d; wr_vld = v;
    mdl_vld[a] = v; mdl_data[a] = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic wait_idle;
    int n;
    n = 0;
    @(negedge clk);
    while ((busy !== 1'b0 || sb.size() > 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 200) begin
      errors++;
      $display("FAIL idle_timeout: busy %b, %0d events pending", busy, sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; id = '0; id_vld = 1'b0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_vld = 1'b0;
    for (int i = 0; i < NEnt; i++) mdl_vld[i] = 1'b0;
    #1;
    checks++;
    if ({clr_id_vld, grant, deny, door_open, busy} !== 5'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected 00000",
               {clr_id_vld, grant, deny, door_open, busy});
    end
    checks++;
    if (grant_cnt !== 8'h00 || deny_cnt !== 8'h00) begin
      errors++;
      $display("FAIL reset_counts: got %h/%h expected 00/00", grant_cnt, deny_cnt);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_empty_deny;
    search(8'h00);
    wait_idle();
    search(8'h3C);
    wait_idle();
  endtask

  task automatic test_grant_index;
    write_entry(0, 8'h3C, 1'b1);
    search(8'h3C);
    wait_idle();
    write_entry(5, 8'hA5, 1'b1);
    search(8'hA5);
    wait_idle();
    write_entry(7, 8'hE7, 1'b1);
    search(8'hE7);
    wait_idle();
    search(8'h3D);
    wait_idle();
  endtask

  task automatic test_lowest_wins;
    write_entry(3, 8'h11, 1'b1);
    write_entry(6, 8'h11, 1'b1);
    search(8'h11);
    wait_idle();
    write_entry(1, 8'h00, 1'b0);
    search(8'h00);
    wait_idle();
  endtask

  task automatic test_hold_during_grant;
    int t;
    drive_id(8'h3C, model_lookup(8'h3C), t);
    while (cyc < t + 5) @(negedge clk);
    checks++;
    if (busy !== 1'b1 || door_open !== 1'b1) begin
      errors++;
      $display("FAIL busy_grant: busy %b door %b expected 1/1", busy, door_open);
    end
    id = 8'h5A;
    id_vld = 1'b1;
    expect_search(t + 18, model_lookup(8'h5A));
    while (cyc < t + 19) @(negedge clk);
    id_vld = 1'b0;
    wait_idle();
  endtask

  task automatic test_write_during_search;
    int t;
    drive_id(8'h77, 2, t);
    write_entry(2, 8'h77, 1'b1);
    wait_idle();
    write_entry(2, 8'h77, 1'b0);
    search(8'h77);
    wait_idle();
  endtask

  task automatic test_reset_mid_grant;
    int t;
    drive_id(8'h3C, model_lookup(8'h3C), t);
    while (cyc < t + 6) @(negedge clk);
    #2;
    checks++;
    if (door_open !== 1'b1) begin
      errors++;
      $display("FAIL door_before_reset: got %b expected 1", door_open);
    end
    rst_n = 1'b0;
    door_hi = -1;
    #1;
    checks++;
    if ({door_open, busy, grant, deny, clr_id_vld} !== 5'b0) begin
      errors++;
      $display("FAIL async_reset: got %b expected 00000",
               {door_open, busy, grant, deny, clr_id_vld});
    end
    sb.delete();
    for (int i = 0; i < NEnt; i++) mdl_vld[i] = 1'b0;
    tb_grants = 0;
    tb_denies = 0;
    @(negedge clk);
    #2 rst_n = 1'b1;
    search(8'h3C);
    wait_idle();
    search(8'hA5);
    wait_idle();
  endtask

  task automatic test_stats;
    int eg, ed;
`ifdef ID_AUTH_STATS_EN
    eg = (tb_grants > 255) ? 255 : tb_grants;
    ed = (tb_denies > 255) ? 255 : tb_denies;
`else
    eg = 0;
    ed = 0;
`endif
    checks++;
    if (grant_cnt !== 8'(eg) || deny_cnt !== 8'(ed)) begin
      errors++;
      $display("FAIL stat_counts: got %h/%h expected %h/%h", grant_cnt, deny_cnt, 8'(eg), 8'(ed));
    end
`ifdef ID_AUTH_STATS_EN
    write_entry(4, 8'hC4, 1'b1);
    for (int i = 0; i < 300; i++) begin
      search(8'hC4);
      wait_idle();
    end
    checks++;
    if (grant_cnt !== 8'hFF || deny_cnt !== 8'(ed)) begin
      errors++;
      $display("FAIL stat_saturate: got %h/%h expected ff/%h", grant_cnt, deny_cnt, 8'(ed));
    end
`endif
  endtask

  initial begin
    test_reset();
    test_empty_deny();
    test_grant_index();
    test_lowest_wins();
    test_hold_during_grant();
    test_write_during_search();
    test_stats();
    test_reset_mid_grant();
    test_stats();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
